// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if
// Groups the request, register-file read port and beat-stream signals of
// the register dump controller.
//   start / first_reg / last_reg  : dump request and inclusive register range
//   readRegnum / readData         : combinational register-file read port
//   dump_data / dump_regnum       : captured beat, qualified by dump_valid
//   dump_valid / dump_ready       : beat handshake
//   busy / done / checksum        : status outputs
// Modports: master = the controller, slave = requester / register file / sink.
interface reg_dump_ctrl_if;
   logic        start;
   logic [4:0]  first_reg;
   logic [4:0]  last_reg;
   logic [4:0]  readRegnum;
   logic [31:0] readData;
   logic [31:0] dump_data;
   logic [4:0]  dump_regnum;
   logic        dump_valid;
   logic        dump_ready;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   modport master (
      input  start, first_reg, last_reg, readData, dump_ready,
      output readRegnum, dump_data, dump_regnum, dump_valid, busy, done, checksum
   );

   modport slave (
      output start, first_reg, last_reg, readData, dump_ready,
      input  readRegnum, dump_data, dump_regnum, dump_valid, busy, done, checksum
   );
endinterface

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
// Streams the register range first_reg..last_reg (inclusive, wrapping
// 31 -> 0) out of a register file, one beat per two cycles at best.
// Ports:
//   clk  : rising-edge clock for all state
//   rst  : synchronous active-high reset
//   bus  : reg_dump_ctrl_if.master (request, read port, beat stream, status)
// Optional feature: define DUMP_CHECKSUM_EN to build a running XOR of all
// accepted beats on bus.checksum; otherwise checksum is tied to zero.
module reg_dump_ctrl (
   input  logic            clk,
   input  logic            rst,
   reg_dump_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  last_q, last_d;
   logic [31:0] dump_data_q, dump_data_d;
   logic [4:0]  dump_regnum_q, dump_regnum_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_d        = last_q;
      dump_data_d   = dump_data_q;
      dump_regnum_d = dump_regnum_q;
      case (state_q)
         IDLE: begin
            // Only the end of the range is kept; the start goes straight
            // into the counter.
            if (bus.start) begin
               cnt_d   = bus.first_reg;
               last_d  = bus.last_reg;
               state_d = READ;
            end
         end
         READ: begin
            dump_data_d   = bus.readData;
            dump_regnum_d = cnt_q;
            state_d       = SEND;
         end
         SEND: begin
            if (bus.dump_ready) begin
               if (cnt_q == last_q) begin
                  state_d = DONE;
               end else begin
                  // 5-bit increment wraps 31 -> 0 for ranges with last < first.
                  cnt_d   = cnt_q + 5'd1;
                  state_d = READ;
               end
            end
         end
         DONE: begin
            // start is deliberately not looked at here, so a start that
            // coincides with the final handshake or the done pulse is dropped.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= 5'd0;
         last_q        <= 5'd0;
         dump_data_q   <= 32'd0;
         dump_regnum_q <= 5'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         dump_data_q   <= dump_data_d;
         dump_regnum_q <= dump_regnum_d;
      end
   end

   assign bus.readRegnum  = (state_q == READ) ? cnt_q : 5'd0;
   assign bus.dump_data   = dump_data_q;
   assign bus.dump_regnum = dump_regnum_q;
   assign bus.dump_valid  = (state_q == SEND);
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);

`ifdef DUMP_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;
   logic        start_acc;
   logic        beat_acc;

   assign start_acc = (state_q == IDLE) && bus.start;
   assign beat_acc  = (state_q == SEND) && bus.dump_ready;

   always_comb begin
      checksum_d = checksum_q;
      if (start_acc) begin
         checksum_d = 32'd0;
      end else if (beat_acc) begin
         checksum_d = checksum_q ^ dump_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= 32'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = 32'd0;
`endif

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl
// Drives directed and randomized dumps into reg_dump_ctrl and compares the
// beat stream, status outputs and checksum against a range/queue model.
module tb_reg_dump_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_dump_ctrl_if bus ();

   reg_dump_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] regfile [32];
   assign bus.readData = regfile[bus.readRegnum];

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [31:0] exp_sum);
      chk({tag, "_busy"},  32'(bus.busy),       32'd0);
      chk({tag, "_done"},  32'(bus.done),       32'd0);
      chk({tag, "_valid"}, 32'(bus.dump_valid), 32'd0);
      chk({tag, "_rdreg"}, 32'(bus.readRegnum), 32'd0);
      chk({tag, "_csum"},  bus.checksum,        exp_sum);
   endtask

   // mode 0: ready always high, 1: random ready, 2: ready low for the first
   // five SEND cycles. poke injects start pulses while busy.
   task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode, input bit poke);
      logic [4:0]  exp_q [$];
      logic [31:0] exp_sum;
      int          n;
      int          idx;
      bit          seen_done;

      // Reference: inclusive modular range f..l, checksum = XOR of the words.
      n = ((int'(l) - int'(f) + 32) % 32) + 1;
      exp_q   = {};
      exp_sum = 32'd0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(5'((int'(f) + i) % 32));
`ifdef DUMP_CHECKSUM_EN
         exp_sum = exp_sum ^ regfile[(int'(f) + i) % 32];
`endif
      end
      $display("dump first=%0d last=%0d beats=%0d mode=%0d poke=%0d", f, l, n, mode, poke);

      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.first_reg  = f;
      bus.last_reg   = l;
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.first_reg  = 5'($urandom);
      bus.last_reg   = 5'($urandom);

      idx       = 0;
      seen_done = 1'b0;
      for (int cyc = 1; cyc <= 2000 && !seen_done; cyc++) begin
         case (mode)
            0:       bus.dump_ready = 1'b1;
            1:       bus.dump_ready = ($urandom_range(0, 3) != 0);
            default: bus.dump_ready = (cyc > 6);
         endcase
         if (poke) bus.start = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         chk("busy", 32'(bus.busy), 32'd1);
         if (bus.done) begin
            seen_done = 1'b1;
            chk("beats_at_done", 32'(idx), 32'(n));
            if (mode == 0) chk("done_latency", 32'(cyc), 32'(2 * n + 1));
            chk("valid_in_done", 32'(bus.dump_valid), 32'd0);
            chk("rdreg_in_done", 32'(bus.readRegnum), 32'd0);
         end else if (bus.dump_valid) begin
            if (idx < n) begin
               chk("beat_regnum", 32'(bus.dump_regnum), 32'(exp_q[idx]));
               chk("beat_data", bus.dump_data, regfile[exp_q[idx]]);
            end else begin
               chk("beat_overrun", 32'(idx), 32'(n - 1));
            end
            chk("rdreg_in_send", 32'(bus.readRegnum), 32'd0);
            if (bus.dump_ready) idx++;
         end else begin
            if (idx < n) chk("rdreg_in_read", 32'(bus.readRegnum), 32'(exp_q[idx]));
            else         chk("read_overrun", 32'(idx), 32'(n - 1));
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk_idle("after_done", exp_sum);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rst_sum;
      bit          got_valid;

      for (int i = 0; i < 32; i++) regfile[i] = 32'h01010101 * 32'(i);
      regfile[13] = 32'h12470000;

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.first_reg  = 5'd0;
      bus.last_reg   = 5'd0;
      bus.dump_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset", 32'd0);
      chk("reset_data", bus.dump_data, 32'd0);
      chk("reset_regnum", 32'(bus.dump_regnum), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed cases with the preloaded register file.
      run_dump(5'd13, 5'd13, 0, 1'b0);
      run_dump(5'd30, 5'd1,  0, 1'b0);
      run_dump(5'd2,  5'd3,  2, 1'b0);
      run_dump(5'd6,  5'd9,  0, 1'b1);
      run_dump(5'd1,  5'd3,  0, 1'b0);
      run_dump(5'd4,  5'd5,  0, 1'b0);

      // Reset during SEND of a full 0..31 dump.
      $display("reset during dump first=0 last=31");
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.first_reg  = 5'd0;
      bus.last_reg   = 5'd31;
      bus.dump_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      got_valid = 1'b0;
      for (int c = 0; c < 10 && !got_valid; c++) begin
         @(negedge clk);
         if (bus.dump_valid && bus.dump_regnum == 5'd2) got_valid = 1'b1;
         else @(posedge clk);
      end
      if (!got_valid) chk("send_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      rst_sum = 32'd0;
      chk_idle("midreset", rst_sum);
      chk("midreset_data", bus.dump_data, 32'd0);
      chk("midreset_regnum", 32'(bus.dump_regnum), 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("postreset_done", 32'(bus.done), 32'd0);
      end
      run_dump(5'd5, 5'd5, 0, 1'b0);

      // Randomized dumps over a random register file.
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 32; i++) regfile[i] = $urandom;
         run_dump(5'($urandom), 5'($urandom), int'($urandom_range(0, 1)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state; rst input 1, synchronous active-high reset.
REQ-002 SHALL have input start, 1 bit: single-cycle request to begin a dump.
REQ-003 SHALL have input first_reg, 5 bits: first register number of the dump range.
REQ-004 SHALL have input last_reg, 5 bits: last register number of the dump range.
REQ-005 SHALL have output readRegnum, 5 bits: drives the register-file read-address port.
REQ-006 SHALL have input readData, 32 bits: combinational read data from the register file for readRegnum.
REQ-007 SHALL have output dump_data, 32 bits: captured register value.
REQ-008 SHALL have output dump_regnum, 5 bits: register number of dump_data.
REQ-009 SHALL have output dump_valid, 1 bit: dump_data and dump_regnum are valid.
REQ-010 SHALL have input dump_ready, 1 bit: the sink accepts the current beat.
REQ-011 SHALL have output busy, 1 bit: a dump is in progress.
REQ-012 SHALL have output done, 1 bit: one-cycle pulse after the last beat is accepted.
REQ-013 SHALL have output checksum, 32 bits: XOR of the accepted words (see Configuration).

Function
REQ-014 SHALL implement the FSM IDLE -> READ -> SEND -> (READ | DONE) -> IDLE.
REQ-015 IDLE: start=1 SHALL latch first_reg/last_reg, load cnt=first_reg, clear checksum, and enter READ on the next edge.
REQ-016 READ: readRegnum SHALL equal cnt; at the clock edge, readData SHALL be captured into dump_data, cnt into dump_regnum, and the FSM SHALL enter SEND (one-cycle read latency).
REQ-017 SEND: dump_valid SHALL be 1; dump_data and dump_regnum SHALL be held stable until dump_valid&&dump_ready.
REQ-018 On a SEND handshake with cnt==last, the FSM SHALL enter DONE; otherwise cnt SHALL increment (5-bit, 31 wraps to 0) and the FSM SHALL enter READ.
REQ-019 Wrap-around: with last_reg<first_reg, the dump SHALL run first..31, then 0..last; first==last SHALL dump exactly one register.
REQ-020 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE; busy=1 in READ, SEND and DONE.
REQ-021 start asserted while busy SHALL be ignored; start and a final handshake in the same cycle SHALL NOT start a new dump.
REQ-022 Changes on first_reg/last_reg after latching SHALL have no effect until the next start.
REQ-023 readRegnum SHALL be 0 in IDLE and DONE; dump_valid SHALL be 0 outside SEND.
REQ-024 Throughput SHALL be at most one beat per two cycles; with dump_ready held high, an N-register dump SHALL finish (done pulse) 2N+1 cycles after start.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, cnt=0, readRegnum=0, dump_data=0, dump_regnum=0, dump_valid=0, busy=0, done=0, checksum=0.
REQ-026 Reset mid-dump SHALL abort without a done pulse; the first start after reset SHALL behave as from power-up.

Configuration
REQ-027 Macro DUMP_CHECKSUM_EN defined: checksum SHALL be cleared on an accepted start and XORed with dump_data on each handshake; it SHALL hold its value from done until the next start.
REQ-028 Macro DUMP_CHECKSUM_EN undefined: checksum SHALL be constant 0; no checksum register SHALL be present.

Verification
REQ-029 Reg file preloaded reg[i]=0x01010101*i, reg13=0x12470000; start with first=13, last=13, dump_ready=1 -> one beat (dump_regnum=13, dump_data=0x12470000), done 3 cycles after start.
REQ-030 first=30, last=1, dump_ready=1 -> beats in order 30,31,0,1; dump_data 0x1E1E1E1E, 0x1F1F1F1F, 0x00000000, 0x01010101; done once.
REQ-031 first=2, last=3, dump_ready low 5 cycles at the first beat -> dump_valid high and dump_data=0x02020202 stable throughout; no beat lost or duplicated.
REQ-032 start pulsed again while busy -> ignored; one done only; beat count unchanged.
REQ-033 rst asserted during SEND of a 0..31 dump -> next cycle all outputs 0, no done; a new start with first=5, last=5 -> single beat 0x05050505.
REQ-034 With DUMP_CHECKSUM_EN, first=1, last=3 -> checksum=0x01010101^0x02020202^0x03030303=0x00000000; first=4, last=5 -> 0x01010101; without the macro, checksum=0 throughout.
